// File: rtl/deserializer.sv
// Serial-to-parallel receiver: gathers MSB-first bits qualified by data_val_i into
// left-aligned words, emitting full words and idle-timeout-flushed short words.
module deserializer #(
  parameter int WIDTH   = 16,
  parameter int MOD_W   = $clog2(WIDTH),
  parameter int TIMEOUT = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [MOD_W-1:0] deser_data_mod_o,
  output logic             deser_data_val_o,
  output logic             busy_o
);

  localparam int CNT_W = MOD_W + 1;
  localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [MOD_W-1:0] TOP_POS  = MOD_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [MOD_W-1:0] w_pos;
  logic             w_emit;
  logic [WIDTH-1:0] w_emit_data;
  logic [MOD_W-1:0] w_emit_mod;
  logic [WIDTH-1:0] r_data;
  logic [MOD_W-1:0] r_mod;
  logic             r_val;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_val   <= w_emit;
      if (w_emit) begin
        r_data <= w_emit_data;
        r_mod  <= w_emit_mod;
      end
    end
  end

  // The shift register is zeroed whenever a word leaves, so a flushed short word
  // already carries zeros in its unused low bits.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_cnt_inc   = r_cnt + 1'b1;
    w_pos       = TOP_POS - r_cnt[MOD_W-1:0];
    w_emit      = 1'b0;
    w_emit_data = '0;
    w_emit_mod  = '0;
    if (data_val_i) begin
      w_shift_nxt[w_pos] = data_i;
      w_gap_nxt          = '0;
      if (w_cnt_inc == FULL_CNT) begin
        w_emit      = 1'b1;
        w_emit_data = w_shift_nxt;
        w_emit_mod  = '0;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = S_COLLECT;
      end
    end else if ((TIMEOUT > 0) && (r_state == S_COLLECT)) begin
      if (r_gap == GAP_LAST) begin
        w_emit      = 1'b1;
        w_emit_data = r_shift;
        w_emit_mod  = r_cnt[MOD_W-1:0];
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
        w_gap_nxt   = '0;
        w_state_nxt = S_IDLE;
      end else begin
        w_gap_nxt = r_gap + 1'b1;
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign busy_o           = (r_state == S_COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed scenarios with fixed expectations, then random
// traffic compared cycle by cycle against a bit-queue model of the receiver.
module tb_deserializer;
  localparam int WIDTH   = 16;
  localparam int MOD_W   = 4;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             srst_i, data_i, data_val_i;
  logic [WIDTH-1:0] deser_data_o;
  logic [MOD_W-1:0] deser_data_mod_o;
  logic             deser_data_val_o, busy_o;

  int checks   = 0;
  int failures = 0;

  deserializer #(.WIDTH(WIDTH), .MOD_W(MOD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .deser_data_o(deser_data_o), .deser_data_mod_o(deser_data_mod_o),
    .deser_data_val_o(deser_data_val_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: received bits live in a queue; a word leaves when the queue
  // holds WIDTH bits or after TIMEOUT idle cycles with a non-empty queue.
  bit               mq[$];
  int               m_gap = 0;
  logic             m_val = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [MOD_W-1:0] m_mod = '0;
  logic             m_busy = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic void model_emit();
    m_data = '0;
    foreach (mq[i]) m_data[WIDTH-1-i] = mq[i];
    m_mod  = MOD_W'(mq.size() % WIDTH);
    m_val  = 1'b1;
    exp_q.push_back(m_data);
    mq.delete();
    m_gap  = 0;
  endfunction

  always @(posedge clk) begin
    m_val = 1'b0;
    if (srst_i) begin
      mq.delete();
      m_gap = 0;
      m_data = '0;
      m_mod = '0;
    end else if (data_val_i) begin
      mq.push_back(data_i);
      m_gap = 0;
      if (mq.size() == WIDTH) model_emit();
    end else if (mq.size() > 0 && TIMEOUT > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) model_emit();
    end
    m_busy = (mq.size() > 0);
  end

  task automatic step(input logic r, input logic v, input logic d);
    @(negedge clk);
    srst_i = r; data_val_i = v; data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (deser_data_val_o !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd0) begin failures++; $display("FAIL reset_mod got=%0d exp=0", deser_data_mod_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (busy_o !== 1'b0 || deser_data_val_o !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b val=%b exp=0/0", busy_o, deser_data_val_o); end
  endtask

  task automatic test_full_word();
    logic [15:0] w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, w[15-i]);
      if (i < 15) begin
        checks++; if (busy_o !== 1'b1 || deser_data_val_o !== 1'b0) begin failures++; $display("FAIL full_busy bit=%0d busy=%b val=%b exp=1/0", i, busy_o, deser_data_val_o); end
      end
    end
    checks++; if (deser_data_val_o !== 1'b1) begin failures++; $display("FAIL full_val got=%b exp=1", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'hA5C3) begin failures++; $display("FAIL full_data got=%h exp=a5c3", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd0) begin failures++; $display("FAIL full_mod got=%0d exp=0", deser_data_mod_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL full_busy_end got=%b exp=0", busy_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (deser_data_val_o !== 1'b0 || deser_data_o !== 16'hA5C3) begin failures++; $display("FAIL full_hold val=%b data=%h exp=0/a5c3", deser_data_val_o, deser_data_o); end
  endtask

  task automatic test_gapped_word();
    logic [15:0] w = 16'h8001;
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, w[15-i]);
      if (deser_data_val_o) n++;
      if (i < 15) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0);
          if (deser_data_val_o) n++;
          checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL gap_busy bit=%0d gap=%0d got=%b exp=1", i, g, busy_o); end
        end
      end
    end
    checks++; if (n != 1 || deser_data_val_o !== 1'b1) begin failures++; $display("FAIL gap_strobes got=%0d last_val=%b exp=1/1", n, deser_data_val_o); end
    checks++; if (deser_data_o !== 16'h8001 || deser_data_mod_o !== 4'd0) begin failures++; $display("FAIL gap_word got=%h/%0d exp=8001/0", deser_data_o, deser_data_mod_o); end
  endtask

  task automatic test_partial();
    logic [4:0] b = 5'b10110;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, b[4-i]);
    for (int g = 1; g <= 4; g++) begin
      step(1'b0, 1'b0, 1'b0);
      if (g < 4) begin
        checks++; if (deser_data_val_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL part_wait idle=%0d val=%b busy=%b exp=0/1", g, deser_data_val_o, busy_o); end
      end
    end
    checks++; if (deser_data_val_o !== 1'b1) begin failures++; $display("FAIL part_val got=%b exp=1", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'hB000 || deser_data_mod_o !== 4'd5) begin failures++; $display("FAIL part_word got=%h/%0d exp=b000/5", deser_data_o, deser_data_mod_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL part_busy got=%b exp=0", busy_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (deser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL part_after val=%b busy=%b exp=0/0", deser_data_val_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w = 32'h1234FFFF;
    int pos[$];
    logic [15:0] got[$];
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, w[31-i]);
      if (deser_data_val_o) begin pos.push_back(i); got.push_back(deser_data_o); end
    end
    checks++; if (pos.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", pos.size()); end
    else begin
      checks++; if (pos[0] != 15 || pos[1] != 31) begin failures++; $display("FAIL b2b_timing got=%0d,%0d exp=15,31", pos[0], pos[1]); end
      checks++; if (got[0] !== 16'h1234 || got[1] !== 16'hFFFF) begin failures++; $display("FAIL b2b_data got=%h,%h exp=1234,ffff", got[0], got[1]); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w = 16'h00FF;
    int n = 0;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, i[0]);
    step(1'b1, 1'b0, 1'b0);
    checks++; if (deser_data_val_o !== 1'b0 || busy_o !== 1'b0 || deser_data_o !== 16'h0) begin failures++; $display("FAIL rstmid_clear val=%b busy=%b data=%h exp=0/0/0000", deser_data_val_o, busy_o, deser_data_o); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, w[15-i]);
      if (deser_data_val_o) n++;
    end
    checks++; if (n != 1 || deser_data_o !== 16'h00FF || deser_data_mod_o !== 4'd0) begin failures++; $display("FAIL rstmid_word n=%0d got=%h/%0d exp=1 00ff/0", n, deser_data_o, deser_data_mod_o); end
  endtask

  task automatic test_timeout_boundary();
    logic [15:0] w = 16'hC5A7;
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0);
        if (deser_data_val_o) n++;
      end
      step(1'b0, 1'b1, w[15-i]);
      if (deser_data_val_o && i < 15) n++;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL tmo_early_strobes got=%0d exp=0", n); end
    checks++; if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hC5A7 || deser_data_mod_o !== 4'd0) begin failures++; $display("FAIL tmo_word val=%b got=%h/%0d exp=1 c5a7/0", deser_data_val_o, deser_data_o, deser_data_mod_o); end
  endtask

  task automatic test_random();
    int dens = 90;
    int words = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 24 == 0) dens = (c % 72 == 0) ? 95 : ((c % 72 == 24) ? 50 : 15);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < dens), $urandom_range(0, 1));
      checks++; if (deser_data_val_o !== m_val || busy_o !== m_busy) begin failures++; $display("FAIL rand_ctl cyc=%0d val=%b busy=%b exp=%b/%b", c, deser_data_val_o, busy_o, m_val, m_busy); end
      checks++; if (deser_data_o !== m_data || deser_data_mod_o !== m_mod) begin failures++; $display("FAIL rand_word cyc=%0d got=%h/%0d exp=%h/%0d", c, deser_data_o, deser_data_mod_o, m_data, m_mod); end
      if (deser_data_val_o) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_sb cyc=%0d got=%h exp=<none>", c, deser_data_o); end
        else begin
          logic [WIDTH-1:0] e = exp_q.pop_front();
          if (deser_data_o !== e) begin failures++; $display("FAIL rand_sb cyc=%0d got=%h exp=%h", c, deser_data_o, e); end
        end
      end
    end
    checks++; if (words < 20 || exp_q.size() != 0) begin failures++; $display("FAIL rand_volume words=%0d pending=%0d exp>=20/0", words, exp_q.size()); end
  endtask

  initial begin
    srst_i = 1'b1; data_val_i = 1'b0; data_i = 1'b0;
    test_reset();
    test_full_word();
    test_gapped_word();
    test_partial();
    test_back_to_back();
    step(1'b0, 1'b0, 1'b0);
    test_reset_mid_word();
    test_timeout_boundary();
    step(1'b1, 1'b0, 1'b0);
    exp_q.delete();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer. Collects an MSB-first serial bit stream, qualified per bit by a valid strobe, into parallel words.
- Emits a one-cycle word strobe with a bit-count field, so both full words and short (data_mod-style) words are recovered.
- Short words are closed by an idle-gap timeout.
- Sits between a serial link front end and the 16-bit parallel datapath.

Parameters:
- WIDTH, 16, parallel word width in bits; must be at least 2.
- MOD_W, $clog2(WIDTH), width of the bit-count field.
- TIMEOUT, 4, number of consecutive idle cycles that flushes a partial word; 0 disables flushing, so only full words are emitted.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- srst_i  input  1  reset, synchronous, active-high.
- data_i  input  1  serial data bit, MSB of the word first.
- data_val_i  input  1  qualifies data_i for the current cycle.
- deser_data_o  output  WIDTH  assembled word, left-aligned (first received bit at [WIDTH-1]).
- deser_data_mod_o  output  MOD_W  number of valid bits in deser_data_o; 0 means WIDTH (full word).
- deser_data_val_o  output  1  one-cycle strobe: deser_data_o and deser_data_mod_o are valid.
- busy_o  output  1  high while a word is partially collected.

Behaviour:
- Reset: while srst_i is high at a clock edge, all outputs, the shift register, the bit counter, the gap counter and the state clear to 0 / IDLE. srst_i has priority over every other event, including a data_val_i in the same cycle.
- States:
  - IDLE: bit count is 0.
  - COLLECT: 1 to WIDTH-1 bits held.
- Bit capture: on each edge where data_val_i=1:
  - shift data_i into bit position [WIDTH-1-cnt];
  - increment cnt;
  - clear the gap counter;
  - in IDLE, go to COLLECT.
- Full word: on the edge capturing bit number WIDTH:
  - register deser_data_o = word (this bit in [0]), deser_data_mod_o = 0, deser_data_val_o = 1;
  - clear cnt and return to IDLE.
  - Latency: the strobe is visible in the cycle immediately after the last bit's sampling edge.
- Back-to-back words: a valid bit in the cycle right after a full word starts the next word with no lost bit. The new word's first bit is captured on the same edge that drops the previous strobe.
- Gap handling in COLLECT with TIMEOUT>0:
  - Each edge with data_val_i=0 increments the gap counter.
  - On the edge where the gap counter would reach TIMEOUT, flush the partial word:
    - deser_data_o = collected bits left-aligned, unused low bits forced 0;
    - deser_data_mod_o = cnt;
    - deser_data_val_o = 1;
    - then return to IDLE.
  - A gap of TIMEOUT-1 cycles followed by a valid bit continues the same word.
  - If a valid bit arrives on the would-be timeout edge, that bit is captured and no flush occurs.
- TIMEOUT=0: COLLECT waits indefinitely; gaps never flush.
- In IDLE, idle cycles are ignored and the gap counter holds at 0.
- deser_data_val_o is high for exactly one cycle per emitted word and is 0 otherwise.
- deser_data_o and deser_data_mod_o hold their last emitted values between strobes.
- busy_o = 1 exactly when the state is COLLECT (registered). It is 0 in the cycle carrying deser_data_val_o for a word that ended with no new bit.
- Reset mid-word: collected bits are discarded and no strobe is produced. Reception restarts with the first valid bit after srst_i deasserts.
- Width rules:
  - cnt is MOD_W+1 bits wide so it can represent WIDTH internally.
  - deser_data_mod_o is cnt truncated to MOD_W bits, so WIDTH maps to 0.
  - The gap counter saturates and is sized for TIMEOUT.

Test Plan:
- Full word: 16 consecutive valid bits of 0xA5C3, MSB first -> one strobe in the cycle after bit 16, deser_data_o=0xA5C3, mod=0; busy_o high from the cycle after bit 1 until the strobe cycle.
- Gapped full word: 0x8001 sent with 3 idle cycles between every bit (TIMEOUT=4) -> no flush; single strobe with 0x8001, mod=0.
- Partial word: 5 bits 1,0,1,1,0 then idle -> strobe on the 4th idle edge with deser_data_o=0xB000, mod=5; busy_o=0 afterwards.
- Back-to-back: 0x1234 immediately followed by 0xFFFF, no gap -> two strobes exactly 16 cycles apart with the correct values, and no dropped bits.
- Reset mid-word: 9 bits sent, srst_i pulsed for 1 cycle, then a full 0x00FF -> no strobe for the 9 bits; one strobe with 0x00FF, mod=0.
- Timeout boundary: 3 bits, then exactly 3 idle cycles, then a valid bit on the 4th cycle, then 12 more bits -> no flush; one full-word strobe with mod=0.
